param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/param_updown_counter.sv | 90 +++++++++
 tb/tb_param_updown_counter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with programmable terminal value, wrap or
// saturate behaviour at the boundaries, range-checked load and one-cycle event pulses.
module param_updown_counter #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             load_err_o
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    logic at_max;
    logic at_min;
    logic load_over;

    // Boundaries are detected by equality before stepping, so the +1/-1 below
    // never runs past MAX_VAL or below zero, even when MAX_VAL is all ones.
    assign at_max    = (count_q == MAX_VAL);
    assign at_min    = (count_q == ZERO);
    assign load_over = (load_val_i > MAX_VAL);

    // NOTE: every always_comb output gets a default first, so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;

        if (load_i) begin
            if (load_over) begin
                count_d    = MAX_VAL;
                load_err_d = 1'b1;
            end else begin
                count_d = load_val_i;
            end
        end else if (en_i) begin
            if (up_i) begin
                if (!at_max) begin
                    count_d = count_q + ONE;
                end else if (!SATURATE) begin
                    count_d = ZERO;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    count_d = count_q - ONE;
                end else if (!SATURATE) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= ZERO;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // Terminal count looks at the current direction, not at the enable.
    assign tc_o       = up_i ? at_max : at_min;
    assign count_o    = count_q;
    assign wrap_o     = wrap_q;
    assign load_err_o = load_err_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: three instances (4-bit/9 wrapping, 4-bit/9
// saturating, 8-bit default wrapping) driven in parallel against an arithmetic model.
module tb_param_updown_counter;

    logic       clk;
    logic       reset_n;
    logic       en_i;
    logic       up_i;
    logic       load_i;
    logic [3:0] lv4;
    logic [7:0] lv8;

    logic [3:0] cnt_a, cnt_b;
    logic [7:0] cnt_c;
    logic       tc_a, tc_b, tc_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       err_a, err_b, err_c;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, one entry per instance.
    int m_cnt [3];
    bit m_wrap[3];
    bit m_err [3];
    int maxv  [3] = '{9, 9, 255};
    bit satv  [3] = '{1'b0, 1'b1, 1'b0};

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_wrap4 (
        .clk(clk), .reset_n(reset_n), .en_i(en_i), .up_i(up_i), .load_i(load_i),
        .load_val_i(lv4), .count_o(cnt_a), .tc_o(tc_a), .wrap_o(wrap_a), .load_err_o(err_a)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat4 (
        .clk(clk), .reset_n(reset_n), .en_i(en_i), .up_i(up_i), .load_i(load_i),
        .load_val_i(lv4), .count_o(cnt_b), .tc_o(tc_b), .wrap_o(wrap_b), .load_err_o(err_b)
    );

    param_updown_counter #(.WIDTH(8)) u_wrap8 (
        .clk(clk), .reset_n(reset_n), .en_i(en_i), .up_i(up_i), .load_i(load_i),
        .load_val_i(lv8), .count_o(cnt_c), .tc_o(tc_c), .wrap_o(wrap_c), .load_err_o(err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] obs_cnt(input int i);
        case (i)
            0:       return {28'd0, cnt_a};
            1:       return {28'd0, cnt_b};
            default: return {24'd0, cnt_c};
        endcase
    endfunction

    function automatic logic [3:0] obs_flags(input int i);
        case (i)
            0:       return {1'b0, tc_a, wrap_a, err_a};
            1:       return {1'b0, tc_b, wrap_b, err_b};
            default: return {1'b0, tc_c, wrap_c, err_c};
        endcase
    endfunction

    // Next state from the behavioural rules: plain integer stepping, then
    // out-of-range results are either folded to the opposite end or discarded.
    function automatic void model_step(input int i, input bit en, input bit up,
                                       input bit ld, input int lv);
        int n;
        m_wrap[i] = 1'b0;
        m_err[i]  = 1'b0;
        if (ld) begin
            if (lv > maxv[i]) begin
                m_cnt[i] = maxv[i];
                m_err[i] = 1'b1;
            end else begin
                m_cnt[i] = lv;
            end
        end else if (en) begin
            n = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
            if (n > maxv[i] || n < 0) begin
                if (!satv[i]) begin
                    m_cnt[i]  = (n < 0) ? maxv[i] : 0;
                    m_wrap[i] = 1'b1;
                end
            end else begin
                m_cnt[i] = n;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 1'b0;
            m_err[i]  = 1'b0;
        end
    endfunction

    task automatic check_all(input string ph);
        logic [3:0] f;
        bit         tc_exp;
        for (int i = 0; i < 3; i++) begin
            f      = obs_flags(i);
            tc_exp = up_i ? (m_cnt[i] == maxv[i]) : (m_cnt[i] == 0);
            check($sformatf("%s/u%0d count", ph, i), obs_cnt(i), m_cnt[i]);
            check($sformatf("%s/u%0d tc", ph, i),    {31'd0, f[2]}, {31'd0, tc_exp});
            check($sformatf("%s/u%0d wrap", ph, i),  {31'd0, f[1]}, {31'd0, m_wrap[i]});
            check($sformatf("%s/u%0d lerr", ph, i),  {31'd0, f[0]}, {31'd0, m_err[i]});
        end
    endtask

    // Drive inputs in the low phase, step the model on the edge, check just after.
    task automatic do_cycle(input string ph, input bit en, input bit up, input bit ld, input int lv);
        en_i   = en;
        up_i   = up;
        load_i = ld;
        lv4    = lv[3:0];
        lv8    = lv[7:0];
        @(posedge clk);
        #1;
        if (!reset_n) begin
            model_reset();
        end else begin
            model_step(0, en, up, ld, lv & 15);
            model_step(1, en, up, ld, lv & 15);
            model_step(2, en, up, ld, lv & 255);
        end
        check_all(ph);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        en_i    = 1'b1;
        up_i    = 1'b1;
        load_i  = 1'b1;
        lv4     = 4'd5;
        lv8     = 8'd5;
        model_reset();

        // Reset holds everything at zero despite active load/enable.
        @(negedge clk);
        do_cycle("rst_up", 1'b1, 1'b1, 1'b1, 5);
        do_cycle("rst_dn", 1'b1, 1'b0, 1'b0, 0);
        #1 reset_n = 1'b1;

        for (int k = 0; k < 12; k++) do_cycle("up12", 1'b1, 1'b1, 1'b0, 0);

        do_cycle("ld1", 1'b0, 1'b0, 1'b1, 1);
        for (int k = 0; k < 3; k++) do_cycle("dnwrap", 1'b1, 1'b0, 1'b0, 0);

        do_cycle("ld8", 1'b0, 1'b1, 1'b1, 8);
        for (int k = 0; k < 3; k++) do_cycle("satup", 1'b1, 1'b1, 1'b0, 0);
        do_cycle("ld1b", 1'b0, 1'b1, 1'b1, 1);
        for (int k = 0; k < 2; k++) do_cycle("satdn", 1'b1, 1'b0, 1'b0, 0);

        do_cycle("ld12", 1'b0, 1'b1, 1'b1, 12);
        do_cycle("ld13", 1'b1, 1'b0, 1'b1, 13);
        do_cycle("ld15", 1'b1, 1'b1, 1'b1, 15);
        do_cycle("ld5en", 1'b1, 1'b1, 1'b1, 5);
        do_cycle("hold", 1'b0, 1'b1, 1'b0, 0);
        do_cycle("ld9", 1'b0, 1'b1, 1'b1, 9);
        do_cycle("ld0win", 1'b1, 1'b1, 1'b1, 0);
        do_cycle("dn0", 1'b1, 1'b0, 1'b0, 0);
        do_cycle("dn0b", 1'b1, 1'b0, 1'b0, 0);

        do_cycle("ld254", 1'b0, 1'b1, 1'b1, 254);
        for (int k = 0; k < 3; k++) do_cycle("w8up", 1'b1, 1'b1, 1'b0, 0);
        do_cycle("w8dn", 1'b1, 1'b0, 1'b0, 0);

        // Asynchronous reset between edges at count 7.
        do_cycle("ld7", 1'b0, 1'b1, 1'b1, 7);
        en_i   = 1'b1;
        up_i   = 1'b0;
        load_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        @(negedge clk);
        do_cycle("arst_edge", 1'b1, 1'b1, 1'b1, 3);
        #1 reset_n = 1'b1;
        do_cycle("resume", 1'b1, 1'b1, 1'b0, 0);
        do_cycle("resume2", 1'b1, 1'b1, 1'b0, 0);

        for (int k = 0; k < 400; k++) begin
            do_cycle("rand",
                     ($urandom % 4) != 0,
                     ($urandom % 2) != 0,
                     ($urandom % 8) == 0,
                     int'($urandom % 256));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
